// File: rtl/aes_128_key_expand.sv
// Iterative AES-128 key schedule: one round key per clock into an 11-entry register file,
// read back through a combinational indexed port once the whole schedule is coherent.
module aes_128_key_expand (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key_in,
    output logic         busy,
    output logic         done,
    output logic         rk_valid,
    input  logic [3:0]   rk_idx,
    output logic [127:0] rk_out
);

    typedef enum logic {S_IDLE, S_EXPAND} state_t;

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        sub_word = {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] t;
        logic [31:0] n0;
        logic [31:0] n1;
        logic [31:0] n2;
        logic [31:0] n3;
        t  = sub_word({k[23:0], k[31:24]}) ^ {rc, 24'h0};
        n0 = k[127:96] ^ t;
        n1 = k[95:64]  ^ n0;
        n2 = k[63:32]  ^ n1;
        n3 = k[31:0]   ^ n2;
        next_key = {n0, n1, n2, n3};
    endfunction

    state_t       state_q, state_d;
    logic [3:0]   rnd_q, rnd_d;
    logic         done_q, done_d;
    logic         vld_q, vld_d;
    logic [127:0] rk_q [0:10];
    logic [3:0]   prev_idx;
    logic [127:0] rk_next;

    assign prev_idx = (rnd_q == 4'd0) ? 4'd0 : rnd_q - 4'd1;
    assign rk_next  = next_key(rk_q[prev_idx], rcon(rnd_q));

    always_comb begin
        state_d = state_q;
        rnd_d   = rnd_q;
        done_d  = 1'b0;
        vld_d   = vld_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_EXPAND;
                    rnd_d   = 4'd1;
                    vld_d   = 1'b0;
                end
            end
            S_EXPAND: begin
                if (rnd_q == 4'd10) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    vld_d   = 1'b1;
                end else begin
                    rnd_d = rnd_q + 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            rnd_q   <= 4'd0;
            done_q  <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rnd_q   <= rnd_d;
            done_q  <= done_d;
            vld_q   <= vld_d;
        end
    end

    // Register file holds data only; its contents are meaningless until vld_q rises.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == S_IDLE && start) begin
                rk_q[0] <= key_in;
            end else if (state_q == S_EXPAND) begin
                rk_q[rnd_q] <= rk_next;
            end
        end
    end

    assign busy     = (state_q == S_EXPAND);
    assign done     = done_q;
    assign rk_valid = vld_q;
    assign rk_out   = (vld_q && rk_idx <= 4'd10) ? rk_q[rk_idx] : 128'h0;

endmodule

// File: doc/aes_128_key_expand.md
# aes_128_key_expand

Iterative AES-128 key schedule that sits directly upstream of the `aes_128` datapath. It accepts one 128-bit cipher key, computes round keys 0–10 at one round key per clock, and stores all eleven in an internal register file. The round keys are then readable through an indexed port, so the encryption core can fetch any round key without recomputing the schedule.

## Interface
Parameters: none; the block is fixed to AES-128 (Nk=4, Nr=10).
- `clk`  in  1  single clock; all state updates on the rising edge
- `rst`  in  1  reset; one clock; reset is synchronous and active-high
- `start`  in  1  request expansion of `key_in`; sampled only in IDLE
- `key_in`  in  128  cipher key; `key_in[127:96]` is word w0 and `key_in[31:0]` is w3 (FIPS-197 byte order, MSB byte first)
- `busy`  out  1  high while the expansion is in progress
- `done`  out  1  one-cycle pulse when round key 10 has been written
- `rk_valid`  out  1  high once all eleven round keys are stored and coherent
- `rk_idx`  in  4  round-key read index, 0–10
- `rk_out`  out  128  round key `rk_idx`; combinational read of the register file

## Operation
- States: IDLE, EXPAND.
- IDLE with `start`=1: on that edge, `rk[0]` <= `key_in`, round counter <= 1, `rk_valid` <= 0, state <= EXPAND. The key is captured only on this edge, so `key_in` may change afterwards.
- EXPAND: each edge writes `rk[r]` from `rk[r-1]`, then r <= r+1. After writing `rk[10]`, the block sets state <= IDLE, `rk_valid` <= 1 and `done` <= 1.
- Round function, with the previous key as w0..w3:
  - t = SubWord(RotWord(w3)) ^ {Rcon[r], 24'h0}
  - n0 = w0^t, n1 = w1^n0, n2 = w2^n1, n3 = w3^n2
- RotWord is a left byte rotate.
- SubWord applies four instances of the AES S-box, implemented as an internal constant table.
- Rcon[1..10] = 01, 02, 04, 08, 10, 20, 40, 80, 1B, 36.
- Round counter is 4 bits and never exceeds 10; there is no wrap-around.
- Read port: `rk_out` = `rk[rk_idx]` when `rk_valid`=1 and `rk_idx`<=10. Otherwise `rk_out` = 128'h0, which covers both indices 11–15 and any read during an expansion.
- `start` while in EXPAND is ignored, with no queueing or restart.
- A `start` arriving in IDLE while `rk_valid`=1 begins a new expansion and drops `rk_valid` on the same edge.

## Timing
- Reset values:
  - state IDLE, `busy`=0, `done`=0, `rk_valid`=0, round counter 0
  - `rk_out`=0, because `rk_valid`=0
  - register-file contents are don't-care
- `start` accepted at edge E: `busy`=1 from after E through edge E+10; `rk[r]` is written at edge E+r.
- After edge E+10: `busy`=0, `done`=1 for exactly one cycle, `rk_valid`=1. Latency from `start` to `done` is 10 cycles.
- `start` asserted in the cycle where `done`=1 is accepted, since the state is already IDLE. This gives back-to-back expansions every 11 cycles.
- `rst` has priority over `start` and any state. Reset mid-EXPAND returns to IDLE next edge with `busy`, `done` and `rk_valid` all 0, and produces no `done` pulse for the aborted run.
- `done` is registered. `rk_out` is combinational from `rk_idx` with zero cycles of read latency.

## Test plan
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, pulse `start`:
  - `done` exactly 10 cycles later
  - `rk_idx`=0 reads back the key
  - `rk_idx`=1 -> a0fafe1788542cb123a339392a6c7605
  - `rk_idx`=10 -> d014f9a8c9ee2589e13f0cc8b6630ca6
- All-zero key:
  - `rk_idx`=1 -> 62636363626363636263636362636363
  - `rk_idx`=10 -> b4ef5bcb3e92e21123e951cf6f8f188e
  - `rk_idx`=12 -> 0
- Key 000102030405060708090a0b0c0d0e0f: `rk_idx`=10 -> 13111d7fe3944a17f307a78b4d2b30c5. Then hold `start` high continuously and check:
  - second `start` during EXPAND is ignored
  - `start` in the `done` cycle launches the next run
  - `busy` never drops early
- Assert `rst` at cycle 5 of an expansion: next cycle `busy`=0, `done` never pulses, `rk_valid`=0, `rk_out`=0. A fresh `start` then completes correctly with the FIPS-197 key.
- Change `key_in` every cycle after `start` is accepted: the stored schedule matches the key sampled at the `start` edge.
- Sweep `rk_idx` 0–15 after `done`: indices 0–10 return the expected keys and 11–15 return 0. During EXPAND every index returns 0.
